// File: rtl/serial_mean_fifo.sv
// serial_mean_fifo: converts 15-bit signed block sums into rounded 12-bit
// means (sum/8) and queues them behind a valid/ready output port.
// Means that arrive while the queue is full are dropped and flagged in a
// sticky overflow bit.
module serial_mean_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [14:0]                in_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [11:0]                out_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [15:0] w_sumExt;
    logic signed [15:0] w_rounded;
    logic signed [15:0] w_shifted;
    logic signed [11:0] w_mean;

    logic [11:0]        r_meanQ;
    logic               r_meanV;

    logic [11:0]        r_mem [DEPTH];
    logic [AW-1:0]      r_wrPtr;
    logic [AW-1:0]      r_rdPtr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    logic               w_outValid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Round half toward +inf by adding 4 before the arithmetic shift, then clamp to 12 bits.
    always_comb begin
        w_sumExt  = {in_sum[14], in_sum};
        w_rounded = w_sumExt + 16'sd4;
        w_shifted = w_rounded >>> 3;
        w_mean    = w_shifted[11:0];
        if (w_shifted > 16'sd2047) begin
            w_mean = 12'sd2047;
        end else if (w_shifted < -16'sd2048) begin
            w_mean = -12'sd2048;
        end
    end

    // One-cycle mean stage: capture the mean on a pulse, valid follows the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meanQ <= '0;
            r_meanV <= 1'b0;
        end else begin
            r_meanV <= in_valid;
            if (in_valid) begin
                r_meanQ <= w_mean;
            end
        end
    end

    assign w_outValid = (r_count != '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = w_outValid & out_ready;
    assign w_push     = r_meanV & (~w_full | w_pop);
    assign w_drop     = r_meanV & w_full & ~w_pop;

    // Storage array is left unreset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_meanQ;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign out_valid  = w_outValid;
    assign out_data   = r_mem[r_rdPtr];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_mean_fifo.sv
// tb_serial_mean_fifo: table-driven rounding/latency vectors plus hand-written
// fill, overflow, simultaneous push/pop and reset sequences, with a queue
// scoreboard checking every accepted output.
module tb_serial_mean_fifo;

    logic               clk;
    logic               rstN;
    logic               inValid;
    logic signed [14:0] inSum;
    logic               outValid;
    logic               outReady;
    logic signed [11:0] outData;
    logic [2:0]         fifoCount;
    logic               overflow;
    logic               clrOvf;

    int nCompared;
    int nMismatched;
    int sbQueue [$];

    typedef struct {
        logic signed [14:0] sum;
        int                 expMean;
    } vecT;

    vecT vectors [7];

    serial_mean_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_sum     (inSum),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .fifo_count (fifoCount),
        .overflow   (overflow),
        .clr_ovf    (clrOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of in_valid with the given sum; caller decides when to drop in_valid.
    task automatic applyStimulus(input logic signed [14:0] sum);
        inValid = 1'b1;
        inSum   = sum;
        tick();
    endtask

    // Scoreboard: every accepted head is compared against the oldest expected mean.
    always @(negedge clk) begin
        if (rstN && outValid && outReady) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sbUnexpectedOutput", int'(outData), 9999);
            end else begin
                checkOutput("sbData", int'(outData), sbQueue.pop_front());
            end
        end
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rstN     = 1'b0;
        inValid  = 1'b0;
        inSum    = '0;
        outReady = 1'b1;
        clrOvf   = 1'b0;

        vectors[0] = '{15'sd16376,  2047};
        vectors[1] = '{15'sd100,    13};
        vectors[2] = '{-15'sd100,   -12};
        vectors[3] = '{-15'sd16384, -2048};
        vectors[4] = '{-15'sd4,     0};
        vectors[5] = '{15'sd3,      0};
        vectors[6] = '{15'sd800,    100};

        repeat (3) tick();
        checkOutput("resetOutValid", int'(outValid), 0);
        checkOutput("resetCount", int'(fifoCount), 0);
        checkOutput("resetOverflow", int'(overflow), 0);
        rstN = 1'b1;
        tick();

        // Rounding and two-cycle latency, one isolated pulse per vector.
        for (int i = 0; i < 7; i++) begin
            sbQueue.push_back(vectors[i].expMean);
            applyStimulus(vectors[i].sum);
            inValid = 1'b0;
            checkOutput("latencyNotYetValid", int'(outValid), 0);
            tick();
            checkOutput("latencyValid", int'(outValid), 1);
            checkOutput("latencyData", int'(outData), vectors[i].expMean);
            checkOutput("latencyCount1", int'(fifoCount), 1);
            tick();
            checkOutput("singleCycleValid", int'(outValid), 0);
            checkOutput("drainCount0", int'(fifoCount), 0);
        end

        // Fill with out_ready low: fifth mean is dropped and overflow sets.
        outReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sbQueue.push_back(i);
            applyStimulus(15'(8 * i));
        end
        inValid = 1'b0;
        tick();
        tick();
        checkOutput("fillCount", int'(fifoCount), 4);
        checkOutput("fillOverflow", int'(overflow), 1);
        outReady = 1'b1;
        repeat (5) tick();
        checkOutput("fillDrainCount", int'(fifoCount), 0);
        checkOutput("overflowSticky", int'(overflow), 1);
        checkOutput("fillSbEmpty", sbQueue.size(), 0);

        // clr_ovf alone clears the flag.
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        checkOutput("clrAlone", int'(overflow), 0);

        // Full with simultaneous push and pop: nothing is dropped.
        outReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sbQueue.push_back(i);
            applyStimulus(15'(8 * i));
        end
        inValid  = 1'b0;
        checkOutput("fullBeforeCount", int'(fifoCount), 4);
        outReady = 1'b1;
        tick();
        checkOutput("fullPushPopCount", int'(fifoCount), 4);
        checkOutput("fullPushPopOverflow", int'(overflow), 0);
        repeat (5) tick();
        checkOutput("fullDrainCount", int'(fifoCount), 0);
        checkOutput("fullSbEmpty", sbQueue.size(), 0);

        // Drop and clear in the same cycle: set wins.
        outReady = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sbQueue.push_back(i);
            applyStimulus(15'(8 * i));
        end
        inValid = 1'b0;
        clrOvf  = 1'b1;
        tick();
        clrOvf  = 1'b0;
        checkOutput("dropClrOverflow", int'(overflow), 1);
        checkOutput("dropClrCount", int'(fifoCount), 4);
        outReady = 1'b1;
        repeat (5) tick();
        checkOutput("dropClrSbEmpty", sbQueue.size(), 0);
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;

        // Reset mid-stream with three queued and one in flight.
        outReady = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(15'(8 * i));
        end
        inValid = 1'b0;
        checkOutput("preResetCount", int'(fifoCount), 3);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetValid", int'(outValid), 0);
        checkOutput("asyncResetCount", int'(fifoCount), 0);
        checkOutput("asyncResetOverflow", int'(overflow), 0);
        sbQueue.delete();
        tick();
        tick();
        rstN     = 1'b1;
        outReady = 1'b1;
        tick();
        checkOutput("inFlightDiscarded", int'(fifoCount), 0);
        sbQueue.push_back(-10);
        applyStimulus(-15'sd80);
        inValid = 1'b0;
        checkOutput("postResetNotYetValid", int'(outValid), 0);
        tick();
        checkOutput("postResetValid", int'(outValid), 1);
        checkOutput("postResetData", int'(outData), -10);
        tick();
        checkOutput("postResetDrained", int'(fifoCount), 0);
        checkOutput("finalSbEmpty", sbQueue.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/serial_mean_fifo.md
# serial_mean_fifo

Downstream consumer of the 8-sample serial accumulator. Each time the accumulator flags a completed 15-bit signed block sum, this block converts the sum to a rounded 12-bit signed mean (sum/8) in a one-cycle pipeline stage. It then buffers the mean in a small FIFO and presents it on a valid/ready output port to the next processing stage. Sums that arrive while the FIFO is full are dropped and recorded in a sticky overflow flag.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  single-cycle pulse: in_sum holds a completed block sum (driven by accumulator sum_valid)
- in_sum  input  15  signed two's-complement block sum of 8 samples
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  downstream accepts the head when out_valid & out_ready
- out_data  output  12  signed mean at FIFO head
- fifo_count  output  $clog2(DEPTH)+1  entries currently stored
- overflow  output  1  sticky: a mean was dropped because the FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

## Operation
- Mean stage:
  - m = (sext16(in_sum) + 4) >>> 3: arithmetic shift, round half toward +inf, 16-bit intermediate.
  - Saturate m to [-2048, 2047] (defensive; legal sums never exceed it).
  - On in_valid, register m into mean_q and set mean_v = 1. When in_valid = 0, mean_v = 0 on the next edge.
- FIFO push: mean_v = 1 pushes mean_q. The write pointer wraps modulo DEPTH.
- FIFO pop: out_valid & out_ready. The read pointer wraps modulo DEPTH.
- out_data = mem[rd_ptr] whenever out_valid = 1. Its value is don't-care when out_valid = 0.
- out_valid = (fifo_count != 0).
- Full (fifo_count == DEPTH):
  - Push with a simultaneous pop: both succeed and the count is unchanged.
  - Push without a pop: the mean is dropped, the count is unchanged, and overflow is set on the next edge.
- Empty: a pop is impossible because out_valid = 0. A push into an empty FIFO is visible at the head on the next cycle.
- Push and pop in the same cycle with the FIFO non-full and non-empty: the count is unchanged.
- overflow:
  - Set on a dropped push.
  - Cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins.
- Input back-to-back pulses (every cycle) are legal. The accumulator produces at most one pulse per 8 cycles, but the block must not rely on that.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, fifo_count = 0, overflow = 0, mean_v = 0, pointers = 0. FIFO memory contents are not reset.
- Latency: in_valid sampled high at edge k → mean_q at edge k → FIFO write at edge k+1 → out_valid high after edge k+1 if the FIFO was empty. This is 2 cycles from pulse to output.
- A pop at edge j removes the head. The next entry, if any, appears at out_data after edge j.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: all stored and in-flight means are discarded immediately. Outputs go to their reset values asynchronously, and operation resumes on the first edge after deassertion.
- rst_n deasserts synchronously to clk (handled externally).

## Test plan
- Rounding: in_sum = 16376, 100, -100, -16384, -4, 3 → out_data = 2047, 13, -12, -2048, 0, 0. Each result appears 2 cycles after its pulse while out_ready = 1.
- Latency and empty: a single pulse with in_sum = 800 and out_ready = 1 → out_valid high for exactly 1 cycle, 2 cycles after the pulse, with out_data = 100. fifo_count goes 0→1→0.
- Fill and overflow (DEPTH = 4): out_ready = 0, 5 pulses with sums 8, 16, 24, 32, 40 → fifo_count = 4 and overflow = 1. Then out_ready = 1 → outputs 1, 2, 3, 4 (the 5 is dropped) and overflow stays 1.
- Full with simultaneous push/pop: with the FIFO full holding 1..4, assert out_ready on the cycle the mean 5 arrives → no overflow, count stays 4, and the drain order is 1, 2, 3, 4, 5.
- Overflow clear: assert clr_ovf alone → overflow = 0 next cycle. Assert clr_ovf in the same cycle as a dropped push → overflow remains 1.
- Reset mid-stream: with 3 entries queued and a pulse in flight, pulse rst_n low → out_valid = 0 and fifo_count = 0 immediately. After release, the next pulse (in_sum = -80) outputs -10 with a 2-cycle latency.
